ex_muldiv: RTL
==============

Name: ex_muldiv

Overview:
Iterative RV32M multiply/divide unit in the execute stage. It consumes funct3E and the M-op qualifier produced by the ID/EX control register, plus the forwarded operands. It stalls the front of the pipeline while it iterates, then presents a 32-bit result for one cycle. The EX result mux selects it alongside the ALU output.

Parameters:
XLEN, 32, operand/result width; also the iteration count for non-special ops.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  valid M-extension op present in EX (opcode OP, funct7=0000001)
flush  input  1  kill in-flight op (branch/jump redirect from EX)
funct3E  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
src_a  input  XLEN  rs1 value after forwarding
src_b  input  XLEN  rs2 value after forwarding
stall  output  1  hold IF/ID/EX (combinational)
done  output  1  result valid this cycle (registered)
result  output  XLEN  op result (registered; holds until next completion)

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset (async): state=IDLE; counter=0; internal accumulators=0; done=0; result=0; stall=0.
- Cycle 0 is the first cycle in which start=1 while in IDLE.
- In cycle 0, capture funct3E, src_a, src_b. Later operand changes are ignored.
- stall = (IDLE & start & ~flush) | BUSY. stall is 0 in DONE, so the pipeline advances on the edge leaving DONE.
- Normal path: IDLE -> BUSY at end of cycle 0, counter=0.
  - BUSY performs one iteration per edge.
  - After XLEN iterations go to DONE. With XLEN=32, done=1 in cycle 33; stall=1 in cycles 0..32.
- DONE -> IDLE unconditionally. start is ignored in DONE, because it is still the same instruction.
- Multiply: shift-add on |operands|.
  - MUL/MULHU/MULH/MULHSU take the magnitude of an operand only if that operand is signed for the op.
  - MULH: both signed. MULHSU: src_a signed, src_b unsigned. MULHU/MUL: unsigned, using a 2*XLEN product.
  - Negate the 2*XLEN product when the signs differ.
  - MUL returns bits [XLEN-1:0]; MULH* return bits [2XLEN-1:XLEN].
- Divide: restoring, one quotient bit per iteration on magnitudes (signed ops) or raw values (unsigned ops).
  - Quotient sign = sign(a)^sign(b).
  - Remainder sign = sign(a).
- Fast path: IDLE -> DONE directly at end of cycle 0; done in cycle 1; stall=1 in cycle 0 only. Cases:
  - Divide by zero (src_b=0): DIV/DIVU -> all ones; REM/REMU -> src_a.
  - Signed overflow (DIV/REM, src_a=0x80000000, src_b=0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- flush in any state: next state IDLE, no done pulse, result unchanged.
  - flush with start in IDLE does not start the op.
  - flush has priority over the DONE->IDLE transition; the result is still not updated.
- Reset mid-operation aborts immediately; all outputs return to reset values.
- done is a single-cycle pulse; result is updated on the same edge that raises done.
- Back-to-back ops: a new start is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3) -> result 0xFFFFFFEB, done only in cycle 33, stall high cycles 0..32, low in cycle 33.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done in cycle 1; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM same -> 0, both in cycle 1.
- DIVU 100/7 with flush=1 in cycle 10:
  - stall low from cycle 11; no done; result keeps its prior value.
  - A new MUL 3x4 started in cycle 12 -> 12 with done in cycle 45.
- Assert reset in cycle 5 of a DIV: stall/done/result read 0 immediately. After release, DIVU 9/3 -> 3 in cycle 33. Changing src_a/src_b during BUSY does not alter the result.

Source files
------------

// File: rtl/ex_muldiv.sv
`timescale 1ns/1ps
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide on magnitudes, one bit per clock.
module ex_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0]   LAST_COUNT = CW'(XLEN - 1);
    localparam logic [CW-1:0]   ONE_C      = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZERO_X     = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_X     = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_X      = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic n);
        return n ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg2(input logic [2*XLEN-1:0] v, input logic n);
        return n ? (~v + {{(2*XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

    state_t            state_r, state_next_s;
    logic [CW-1:0]     count_r;
    logic [2:0]        op_r;
    logic              neg_r;
    logic [XLEN-1:0]   opb_r;
    logic [2*XLEN-1:0] acc_r;
    logic              done_r;
    logic [XLEN-1:0]   result_r;

    logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s, neg_start_s;
    logic [XLEN-1:0]   mag_a_s, mag_b_s;
    logic              fast_s;
    logic [XLEN-1:0]   fast_result_s;
    logic              accept_s, finish_s, load_result_s;
    logic [XLEN:0]     mul_sum_s, rem_sh_s;
    logic [XLEN-1:0]   div_diff_s;
    logic              div_ge_s;
    logic [2*XLEN-1:0] iter_s, prod_s;
    logic [XLEN-1:0]   final_s, next_result_s;

    // Operand decode, special-case detection and the per-iteration datapath
    always_comb begin
        a_signed_s  = (funct3E == OP_MULH) | (funct3E == OP_MULHSU) |
                      (funct3E == OP_DIV)  | (funct3E == OP_REM);
        b_signed_s  = (funct3E == OP_MULH) | (funct3E == OP_DIV) | (funct3E == OP_REM);
        a_neg_s     = a_signed_s & src_a[XLEN-1];
        b_neg_s     = b_signed_s & src_b[XLEN-1];
        mag_a_s     = cond_neg(src_a, a_neg_s);
        mag_b_s     = cond_neg(src_b, b_neg_s);
        // Remainder follows the dividend; everything else follows the sign product
        neg_start_s = (funct3E == OP_REM) ? a_neg_s : (a_neg_s ^ b_neg_s);

        fast_s        = 1'b0;
        fast_result_s = ZERO_X;
        if (funct3E[2] && (src_b == ZERO_X)) begin
            fast_s        = 1'b1;
            fast_result_s = funct3E[1] ? src_a : ONES_X;
        end else if (funct3E[2] && !funct3E[0] && (src_a == MIN_X) && (src_b == ONES_X)) begin
            fast_s        = 1'b1;
            fast_result_s = funct3E[1] ? ZERO_X : MIN_X;
        end else begin
            fast_s        = 1'b0;
            fast_result_s = ZERO_X;
        end

        mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opb_r} : {(XLEN+1){1'b0}});
        rem_sh_s   = acc_r[2*XLEN-1:XLEN-1];
        div_ge_s   = rem_sh_s >= {1'b0, opb_r};
        div_diff_s = rem_sh_s[XLEN-1:0] - opb_r;
        if (op_r[2]) begin
            iter_s = {(div_ge_s ? div_diff_s : rem_sh_s[XLEN-1:0]), acc_r[XLEN-2:0], div_ge_s};
        end else begin
            iter_s = {mul_sum_s, acc_r[XLEN-1:1]};
        end

        prod_s = cond_neg2(iter_s, neg_r);
        case (op_r)
            OP_MUL:                       final_s = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: final_s = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              final_s = cond_neg(iter_s[XLEN-1:0], neg_r);
            OP_REM, OP_REMU:              final_s = cond_neg(iter_s[2*XLEN-1:XLEN], neg_r);
            default:                      final_s = ZERO_X;
        endcase
    end

    // Next-state logic, result load selection and the pipeline stall
    always_comb begin
        state_next_s  = state_r;
        accept_s      = (state_r == IDLE) & start & ~flush;
        finish_s      = (state_r == BUSY) & ~flush & (count_r == LAST_COUNT);
        load_result_s = 1'b0;
        next_result_s = result_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = fast_s ? DONE : BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                if (flush) begin
                    state_next_s = IDLE;
                end else if (count_r == LAST_COUNT) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
        if (accept_s && fast_s) begin
            load_result_s = 1'b1;
            next_result_s = fast_result_s;
        end else if (finish_s) begin
            load_result_s = 1'b1;
            next_result_s = final_s;
        end else begin
            load_result_s = 1'b0;
            next_result_s = result_r;
        end
        stall = ~reset & (accept_s | (state_r == BUSY));
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Operand capture and iteration accumulators
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= '0;
            op_r    <= 3'b000;
            neg_r   <= 1'b0;
            opb_r   <= ZERO_X;
            acc_r   <= {(2*XLEN){1'b0}};
        end else if (accept_s) begin
            count_r <= '0;
            op_r    <= funct3E;
            neg_r   <= neg_start_s;
            opb_r   <= mag_b_s;
            acc_r   <= {ZERO_X, mag_a_s};
        end else if ((state_r == BUSY) && !flush) begin
            count_r <= count_r + ONE_C;
            acc_r   <= iter_s;
        end
    end

    // Registered completion pulse and held result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_r   <= 1'b0;
            result_r <= ZERO_X;
        end else begin
            done_r   <= load_result_s;
            result_r <= next_result_s;
        end
    end

    assign done   = done_r;
    assign result = result_r;

endmodule
